router_pkt_register_p: RTL and testbench

Parametrised packet input register for the 1x3 router, successor to the fixed 8-bit input register stage. It sits between the source port and the three destination FIFOs. It captures and forwards the header, buffers payload through a SKID_DEPTH-entry skid buffer while the selected FIFO is full, and checks both the packet check byte and the header length field. It owns its packet FSM, so it needs no external ld/laf/lfd state inputs.

---
 rtl/router_pkt_register_p_if.sv | 36 +++
 rtl/router_pkt_register_p.sv | 168 ++++++++++++++++
 tb/tb_router_pkt_register_p.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_register_p_if.sv
// Source/destination-side bus of the router packet input register.
//   pkt_valid : source marks header/payload bytes (low on the check byte)
//   din       : packet byte from the source
//   busy      : register asks the source to hold its byte
//   dout      : byte towards the selected destination FIFO
//   wr_en     : dout is valid this cycle
//   fifo_full : full flag of the selected destination FIFO
// master = environment (source + FIFO side), slave = the register.
interface router_pkt_register_p_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              pkt_valid;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              wr_en;
    logic              fifo_full;

    modport master (
        output pkt_valid,
        output din,
        output fifo_full,
        input  busy,
        input  dout,
        input  wr_en
    );

    modport slave (
        input  pkt_valid,
        input  din,
        input  fifo_full,
        output busy,
        output dout,
        output wr_en
    );
endinterface

// File: rtl/router_pkt_register_p.sv
// Parametrised packet input register for the 1x3 router.
// Captures the header (destination + payload length), buffers every header and
// payload byte through a small skid FIFO towards the selected destination FIFO,
// and checks the trailing check byte (XOR or additive) and the length field.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : pkt_valid/din/busy source side, dout/wr_en/fifo_full FIFO side
//   rst_in_reg    : soft clear of low_pkt_valid
//   dest          : destination latched from the header
//   parity_done   : one-cycle pulse after the check byte is accepted
//   low_pkt_valid : check byte received (sticky until rst_in_reg)
//   err_parity    : check byte mismatch, held until the next header
//   err_len       : payload count differs from the header length field
// DATA_W must be >= 4; SKID_DEPTH must be a power of 2 and >= 2.
module router_pkt_register_p #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SKID_DEPTH  = 4,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    router_pkt_register_p_if.slave        bus,
    input  logic                          rst_in_reg,
    output logic [1:0]                    dest,
    output logic                          parity_done,
    output logic                          low_pkt_valid,
    output logic                          err_parity,
    output logic                          err_len
);
    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
    localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned LEN_W = DATA_W - 2;
    localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};
    localparam logic [OCC_W-1:0] BUSY_LVL = OCC_W'(SKID_DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StPayload} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        dest_q, dest_d;
    logic              wr_en_q, wr_en_d;
    logic              pdone_q, pdone_d;
    logic              low_q, low_d;
    logic              errp_q, errp_d;
    logic              errl_q, errl_d;

    logic busy_w, accept, push, chk, pop;

    // Busy from registered occupancy leaves room for the one byte that may
    // still be accepted this cycle.
    always_comb begin
        busy_w = (occ_q >= BUSY_LVL);
        accept = !busy_w && ((state_q == StIdle && bus.pkt_valid) || state_q == StPayload);
        push   = accept && bus.pkt_valid;
        chk    = accept && !bus.pkt_valid;
        pop    = (occ_q != '0) && !bus.fifo_full;
    end

    // Packet FSM and check datapath.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        errp_d  = errp_q;
        errl_d  = errl_q;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    dest_d  = bus.din[1:0];
                    len_d   = bus.din[DATA_W-1:2];
                    acc_d   = bus.din;
                    cnt_d   = '0;
                    errp_d  = 1'b0;
                    errl_d  = 1'b0;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (push) begin
                    if (PARITY_MODE == 1) acc_d = acc_q + bus.din;
                    else                  acc_d = acc_q ^ bus.din;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);
                end else if (chk) begin
                    errp_d  = (acc_q != bus.din);
                    errl_d  = (cnt_q != len_q);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Skid buffer bookkeeping and output register.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        // Pop reads the pre-edge head, so a same-cycle push never overtakes it.
        dout_d  = pop ? mem_q[rd_ptr_q] : dout_q;
        wr_en_d = pop;
        pdone_d = chk;
        // A check byte setting the flag wins over the soft clear.
        if (chk)             low_d = 1'b1;
        else if (rst_in_reg) low_d = 1'b0;
        else                 low_d = low_q;
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
            wr_en_q  <= 1'b0;
            pdone_q  <= 1'b0;
            low_q    <= 1'b0;
            errp_q   <= 1'b0;
            errl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
            wr_en_q  <= wr_en_d;
            pdone_q  <= pdone_d;
            low_q    <= low_d;
            errp_q   <= errp_d;
            errl_q   <= errl_d;
        end
    end

    assign bus.busy      = busy_w;
    assign bus.dout      = dout_q;
    assign bus.wr_en     = wr_en_q;
    assign dest          = dest_q;
    assign parity_done   = pdone_q;
    assign low_pkt_valid = low_q;
    assign err_parity    = errp_q;
    assign err_len       = errl_q;
endmodule

// File: tb/tb_router_pkt_register_p.sv
// Bench for router_pkt_register_p: an XOR-mode and an additive-mode instance
// share one stimulus stream and are checked every cycle against a packet-level
// model, plus literal expectations for the directed packets.
module tb_router_pkt_register_p;
    localparam int unsigned DW = 8;
    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       fifo_full = 1'b0;
    logic       rst_in_reg = 1'b0;

    always #5 clk = ~clk;

    router_pkt_register_p_if #(.DATA_W(DW)) bus0 ();
    router_pkt_register_p_if #(.DATA_W(DW)) bus1 ();

    assign bus0.pkt_valid = pkt_valid;
    assign bus0.din       = din;
    assign bus0.fifo_full = fifo_full;
    assign bus1.pkt_valid = pkt_valid;
    assign bus1.din       = din;
    assign bus1.fifo_full = fifo_full;

    logic [1:0] dest0, dest1;
    logic       pd0, pd1, low0, low1, ep0, ep1, el0, el1;

    router_pkt_register_p #(.DATA_W(DW), .SKID_DEPTH(SD), .PARITY_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .rst_in_reg(rst_in_reg),
        .dest(dest0), .parity_done(pd0), .low_pkt_valid(low0),
        .err_parity(ep0), .err_len(el0)
    );

    router_pkt_register_p #(.DATA_W(DW), .SKID_DEPTH(SD), .PARITY_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .rst_in_reg(rst_in_reg),
        .dest(dest1), .parity_done(pd1), .low_pkt_valid(low1),
        .err_parity(ep1), .err_len(el1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- side-input driver ----------------
    bit rand_on   = 1'b0;
    bit ff_force  = 1'b0;
    bit rir_force = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rand_on) begin
            fifo_full  = ($urandom_range(0, 99) < 30);
            rst_in_reg = ($urandom_range(0, 99) < 10);
        end else begin
            fifo_full  = ff_force;
            rst_in_reg = rir_force;
        end
    end

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];           // bytes accepted but not yet handed to dout
    bit         m_in_pkt;
    logic [5:0] m_len, m_cnt;
    logic [7:0] m_acc0, m_acc1, m_dout;
    logic [1:0] m_dest;
    bit         m_wr, m_pd, m_low, m_ep0, m_ep1, m_el, m_took;

    always @(posedge clk) begin : model
        int sz;
        bit acc;
        bit pop;
        if (rst) begin
            mq.delete();
            m_in_pkt = 0; m_len = 0; m_cnt = 0; m_acc0 = 0; m_acc1 = 0;
            m_dout = 0; m_dest = 0; m_wr = 0; m_pd = 0; m_low = 0;
            m_ep0 = 0; m_ep1 = 0; m_el = 0; m_took = 0;
        end else begin
            sz     = mq.size();
            acc    = (sz < SD - 1) && (m_in_pkt || pkt_valid);
            m_took = acc;
            pop    = (sz > 0) && !fifo_full;
            m_wr   = pop;
            if (pop) m_dout = mq.pop_front();
            m_pd = 0;
            if (acc && pkt_valid) begin
                mq.push_back(din);
                if (!m_in_pkt) begin
                    m_in_pkt = 1;
                    m_dest = din[1:0];
                    m_len = din[7:2];
                    m_acc0 = din;
                    m_acc1 = din;
                    m_cnt = 0;
                    m_ep0 = 0; m_ep1 = 0; m_el = 0;
                end else begin
                    m_acc0 = m_acc0 ^ din;
                    m_acc1 = m_acc1 + din;
                    if (m_cnt != 6'd63) m_cnt = m_cnt + 6'd1;
                end
            end else if (acc) begin
                m_in_pkt = 0;
                m_pd = 1;
                m_ep0 = (m_acc0 != din);
                m_ep1 = (m_acc1 != din);
                m_el = (m_cnt != m_len);
            end
            if (m_pd) m_low = 1;
            else if (rst_in_reg) m_low = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         chk_on = 1'b0;
    bit         saw_busy = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (chk_on) begin
            check("dout0",  32'(bus0.dout),  32'(m_dout));
            check("wr_en0", 32'(bus0.wr_en), 32'(m_wr));
            check("busy0",  32'(bus0.busy),  32'(mq.size() >= SD - 1));
            check("dest0",  32'(dest0),      32'(m_dest));
            check("pdone0", 32'(pd0),        32'(m_pd));
            check("low0",   32'(low0),       32'(m_low));
            check("eplen0", 32'(el0),        32'(m_el));
            check("epar0",  32'(ep0),        32'(m_ep0));
            check("dout1",  32'(bus1.dout),  32'(m_dout));
            check("wr_en1", 32'(bus1.wr_en), 32'(m_wr));
            check("busy1",  32'(bus1.busy),  32'(mq.size() >= SD - 1));
            check("dest1",  32'(dest1),      32'(m_dest));
            check("pdone1", 32'(pd1),        32'(m_pd));
            check("low1",   32'(low1),       32'(m_low));
            check("eplen1", 32'(el1),        32'(m_el));
            check("epar1",  32'(ep1),        32'(m_ep1));
            if (bus0.busy) saw_busy = 1'b1;
            if (bus0.wr_en) rx_q.push_back(bus0.dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] pay [0:79];

    function automatic logic [7:0] pxor(input logic [7:0] h, input int n);
        logic [7:0] r = h;
        for (int i = 0; i < n; i++) r = r ^ pay[i];
        return r;
    endfunction

    function automatic logic [7:0] psum(input logic [7:0] h, input int n);
        logic [7:0] r = h;
        for (int i = 0; i < n; i++) r = r + pay[i];
        return r;
    endfunction

    // Present a byte and hold it until the edge that accepts it.
    task automatic send_byte(input bit pv, input logic [7:0] d);
        pkt_valid = pv;
        din = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (m_took) return;
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] c);
        send_byte(1'b1, hdr);
        for (int i = 0; i < n; i++) send_byte(1'b1, pay[i]);
        send_byte(1'b0, c);
        pkt_valid = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (mq.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_rx[%0d]", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [5:0] hlen;
        logic [7:0] hdr, c;

        @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy",  32'(bus0.busy),  0);
        check("rst_dout",  32'(bus0.dout),  0);
        check("rst_wr_en", 32'(bus0.wr_en), 0);
        check("rst_dest",  32'(dest0),      0);
        check("rst_low",   32'(low0),       0);

        // Basic packet; additive instance sees 0x73 != 0x0D.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        rx_q.delete();
        send_pkt(8'h0D, 3, 8'h0D);
        check("A_pdone", 32'(pd0), 1);
        check("A_epar0", 32'(ep0), 0);
        check("A_elen0", 32'(el0), 0);
        check("A_low0",  32'(low0), 1);
        check("A_dest0", 32'(dest0), 1);
        check("A_epar1", 32'(ep1), 1);
        wait_drain();
        exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        check_rx("A");

        // Bad check byte, then the next header clears the flags.
        send_pkt(8'h0D, 3, 8'h0E);
        check("B_epar0", 32'(ep0), 1);
        check("B_elen0", 32'(el0), 0);
        send_byte(1'b1, 8'h04);
        check("B_clear_epar0", 32'(ep0), 0);
        check("B_clear_elen0", 32'(el0), 0);
        send_byte(1'b1, 8'h55);
        send_byte(1'b0, 8'h51);
        pkt_valid = 1'b0;
        check("B2_epar0", 32'(ep0), 0);

        // Additive checksum, correct for mode 1.
        send_pkt(8'h0D, 3, 8'h73);
        check("C_epar1", 32'(ep1), 0);
        check("C_epar0", 32'(ep0), 1);

        // Length mismatch, then a back-to-back zero-length packet.
        send_pkt(8'h09, 3, 8'h09);
        check("D_elen0", 32'(el0), 1);
        check("D_epar0", 32'(ep0), 0);
        send_pkt(8'h02, 0, 8'h02);
        check("E_dest0", 32'(dest0), 2);
        check("E_elen0", 32'(el0), 0);
        check("E_epar0", 32'(ep0), 0);
        check("E_epar1", 32'(ep1), 0);
        wait_drain();

        // Soft clear of low_pkt_valid.
        rir_force = 1'b1;
        @(posedge clk);
        #1 rir_force = 1'b0;
        check("F_low_cleared", 32'(low0), 0);

        // Six-cycle stall in the middle of a 10-byte payload.
        for (int i = 0; i < 10; i++) pay[i] = 8'h30 + 8'(i);
        c = pxor(8'h2A, 10);
        rx_q.delete();
        saw_busy = 1'b0;
        fork
            send_pkt(8'h2A, 10, c);
            begin
                repeat (4) @(posedge clk);
                #1 ff_force = 1'b1;
                repeat (6) @(posedge clk);
                #1 ff_force = 1'b0;
            end
        join
        wait_drain();
        check("G_saw_busy", 32'(saw_busy), 1);
        check("G_epar0", 32'(ep0), 0);
        exp_q.delete();
        exp_q.push_back(8'h2A);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h30 + 8'(i));
        check_rx("G");

        // Payload count saturates at 63 for a 70-byte payload.
        for (int i = 0; i < 70; i++) pay[i] = 8'($urandom);
        send_pkt(8'hFF, 70, pxor(8'hFF, 70));
        check("H_elen0", 32'(el0), 0);
        check("H_epar0", 32'(ep0), 0);
        check("H_dest0", 32'(dest0), 3);
        wait_drain();

        // Reset after the second payload byte discards the buffered bytes.
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        pkt_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete();
        check("R_wr_en", 32'(bus0.wr_en), 0);
        check("R_dout",  32'(bus0.dout),  0);
        check("R_dest",  32'(dest0),      0);
        check("R_low",   32'(low0),       0);
        check("R_pdone", 32'(pd0),        0);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_pkt(8'h0D, 3, 8'h0D);
        check("R2_epar0", 32'(ep0), 0);
        check("R2_elen0", 32'(el0), 0);
        wait_drain();
        exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
        check_rx("R2");

        // Randomised traffic with random FIFO back-pressure and soft clears.
        rand_on = 1'b1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(0, 12);
            hlen = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 15)) : 6'(n);
            hdr = {hlen, 2'($urandom_range(0, 3))};
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       c = 8'($urandom);
                1:       c = psum(hdr, n);
                default: c = pxor(hdr, n);
            endcase
            send_pkt(hdr, n, c);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
